// File: rtl/lsu_align_ctrl_if.sv
// ============================================================================
// Module      : lsu_align_ctrl_if
// Description : Request, memory-beat and response bundle for lsu_align_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_align_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_store;
    logic [2:0]        i_req_type;
    logic [ADDR_W-1:0] i_req_addr;
    logic [31:0]       i_req_wdata;

    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [3:0]        o_mem_bmask;
    logic [31:0]       o_mem_wdata;
    logic              i_mem_rvalid;
    logic [31:0]       i_mem_rdata;

    logic              o_rsp_valid;
    logic [31:0]       o_rsp_data;
    logic              o_rsp_err;

    modport slave (
        input  i_req_valid, i_req_store, i_req_type, i_req_addr, i_req_wdata,
        input  i_mem_rvalid, i_mem_rdata,
        output o_req_ready,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_bmask, o_mem_wdata,
        output o_rsp_valid, o_rsp_data, o_rsp_err
    );

    modport master (
        output i_req_valid, i_req_store, i_req_type, i_req_addr, i_req_wdata,
        output i_mem_rvalid, i_mem_rdata,
        input  o_req_ready,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_bmask, o_mem_wdata,
        input  o_rsp_valid, o_rsp_data, o_rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/lsu_align_ctrl.sv
// ============================================================================
// Module      : lsu_align_ctrl
// Description : Load/store alignment controller; splits word-crossing accesses
//               into two aligned beats, merges and extends load data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align_ctrl #(
    parameter int ADDR_W           = 32,
    parameter bit SUPPORT_MISALIGN = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    lsu_align_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT0 = 3'd1,
        S_WAIT0 = 3'd2,
        S_BEAT1 = 3'd3,
        S_WAIT1 = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              store_q;
    logic [2:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic              split_q;
    logic [31:0]       lo_q;
    logic [31:0]       hi_q;

    function automatic logic [3:0] size_mask(input logic [2:0] t);
        case (t[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Request decode (valid only while IDLE)
    // ------------------------------------------------------------------
    logic        w_illegal;
    logic        w_split;
    logic        w_accept;
    logic [3:0]  w_req_mask;
    logic [31:0] w_req_wmask;

    always_comb begin
        if (bus.i_req_store)
            w_illegal = (bus.i_req_type >= 3'b011);
        else
            w_illegal = (bus.i_req_type == 3'b011) || (bus.i_req_type == 3'b110) ||
                        (bus.i_req_type == 3'b111);
    end

    assign w_split = ((bus.i_req_type[1:0] == 2'b01) && (bus.i_req_addr[1:0] == 2'b11)) ||
                     ((bus.i_req_type[1:0] == 2'b10) && (bus.i_req_addr[1:0] != 2'b00));

    assign w_accept    = (state_q == S_IDLE) && bus.i_req_valid;
    assign w_req_mask  = size_mask(bus.i_req_type);
    // Clearing bytes beyond the access size keeps unused write lanes at zero.
    assign w_req_wmask = {{8{w_req_mask[3]}}, {8{w_req_mask[2]}},
                          {8{w_req_mask[1]}}, {8{w_req_mask[0]}}};

    // ------------------------------------------------------------------
    // Lane steering shared by both beats
    // ------------------------------------------------------------------
    logic [1:0]        w_off;
    logic [7:0]        w_lanes;
    logic [63:0]       w_wshift;
    logic [31:0]       w_merge;
    logic [ADDR_W-1:0] w_word_addr;
    logic [ADDR_W-1:0] w_next_addr;
    logic [31:0]       w_ext;

    assign w_off       = addr_q[1:0];
    assign w_lanes     = {4'b0000, size_mask(type_q)} << w_off;
    assign w_wshift    = {32'd0, wdata_q} << {w_off, 3'b000};
    assign w_merge     = 32'({hi_q, lo_q} >> {w_off, 3'b000});
    assign w_word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign w_next_addr = w_word_addr + {{(ADDR_W-3){1'b0}}, 3'b100};

    always_comb begin
        case (type_q)
            3'b000:  w_ext = {{24{w_merge[7]}}, w_merge[7:0]};
            3'b001:  w_ext = {{16{w_merge[15]}}, w_merge[15:0]};
            3'b100:  w_ext = {24'd0, w_merge[7:0]};
            3'b101:  w_ext = {16'd0, w_merge[15:0]};
            default: w_ext = w_merge;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.o_req_ready = 1'b0;
        bus.o_mem_req   = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_bmask = 4'b0000;
        bus.o_mem_wdata = 32'd0;
        bus.o_rsp_valid = 1'b0;
        bus.o_rsp_data  = 32'd0;
        bus.o_rsp_err   = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.o_req_ready = 1'b1;
                if (bus.i_req_valid) begin
                    if (w_illegal || (w_split && !SUPPORT_MISALIGN))
                        state_d = S_DONE;
                    else
                        state_d = S_BEAT0;
                end
            end
            S_BEAT0: begin
                bus.o_mem_req   = 1'b1;
                bus.o_mem_we    = store_q;
                bus.o_mem_addr  = w_word_addr;
                bus.o_mem_bmask = w_lanes[3:0];
                bus.o_mem_wdata = w_wshift[31:0];
                if (!store_q)
                    state_d = S_WAIT0;
                else
                    state_d = split_q ? S_BEAT1 : S_DONE;
            end
            S_WAIT0: begin
                if (bus.i_mem_rvalid)
                    state_d = split_q ? S_BEAT1 : S_DONE;
            end
            S_BEAT1: begin
                bus.o_mem_req   = 1'b1;
                bus.o_mem_we    = store_q;
                bus.o_mem_addr  = w_next_addr;
                bus.o_mem_bmask = w_lanes[7:4];
                bus.o_mem_wdata = w_wshift[63:32];
                state_d         = store_q ? S_DONE : S_WAIT1;
            end
            S_WAIT1: begin
                if (bus.i_mem_rvalid)
                    state_d = S_DONE;
            end
            S_DONE: begin
                bus.o_rsp_valid = 1'b1;
                bus.o_rsp_err   = err_q;
                bus.o_rsp_data  = (store_q || err_q) ? 32'd0 : w_ext;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and load merge buffer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            store_q <= 1'b0;
            type_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            lo_q    <= 32'd0;
            hi_q    <= 32'd0;
        end else begin
            if (w_accept) begin
                store_q <= bus.i_req_store;
                type_q  <= bus.i_req_type;
                addr_q  <= bus.i_req_addr;
                wdata_q <= bus.i_req_wdata & w_req_wmask;
                err_q   <= w_illegal || (w_split && !SUPPORT_MISALIGN);
                split_q <= w_split;
                lo_q    <= 32'd0;
                hi_q    <= 32'd0;
            end
            if ((state_q == S_WAIT0) && bus.i_mem_rvalid)
                lo_q <= bus.i_mem_rdata;
            if ((state_q == S_WAIT1) && bus.i_mem_rvalid)
                hi_q <= bus.i_mem_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_align_ctrl.sv
// ============================================================================
// Module      : tb_lsu_align_ctrl
// Description : Directed bench for lsu_align_ctrl with a one-cycle memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_align_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_align_ctrl_if #(.ADDR_W(32)) bus ();
    lsu_align_ctrl_if #(.ADDR_W(32)) bus_nm ();

    lsu_align_ctrl #(.ADDR_W(32), .SUPPORT_MISALIGN(1'b1)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    lsu_align_ctrl #(.ADDR_W(32), .SUPPORT_MISALIGN(1'b0)) dut_nm (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_nm)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [0:127];

    // memory model: read data returned one cycle after the beat
    logic        pend      = 1'b0;
    logic [31:0] pend_data = 32'd0;
    logic        resp_en   = 1'b1;
    logic        inj_valid = 1'b0;
    logic [31:0] inj_data  = 32'd0;

    always @(negedge clk) begin
        bus.i_mem_rvalid = resp_en ? pend : inj_valid;
        bus.i_mem_rdata  = resp_en ? pend_data : inj_data;
        pend      = 1'b0;
        pend_data = 32'd0;
        if (bus.o_mem_req && resp_en) begin
            if (bus.o_mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.o_mem_bmask[b])
                        mem[bus.o_mem_addr[8:2]][8*b +: 8] = bus.o_mem_wdata[8*b +: 8];
            end else begin
                pend      = 1'b1;
                pend_data = mem[bus.o_mem_addr[8:2]];
            end
        end
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          nbeats;
    int          lat;
    logic        got_rsp;
    logic [31:0] b_addr  [2];
    logic [3:0]  b_mask  [2];
    logic [31:0] b_wdata [2];
    logic        b_we    [2];
    logic [31:0] r_data;
    logic        r_err;

    task automatic access(input string tag, input logic st, input logic [2:0] ty,
                          input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_req_store = st;
        bus.i_req_type  = ty;
        bus.i_req_addr  = a;
        bus.i_req_wdata = wd;
        check_vec({tag, "/ready"}, bus.o_req_ready, 1);
        check_vec({tag, "/idle_rsp"}, bus.o_rsp_valid, 0);
        @(posedge clk);
        nbeats  = 0;
        lat     = 0;
        got_rsp = 1'b0;
        r_data  = 32'd0;
        r_err   = 1'b0;
        for (int c = 1; c <= 20 && !got_rsp; c++) begin
            @(negedge clk);
            bus.i_req_valid = 1'b0;
            if (bus.o_mem_req) begin
                if (nbeats < 2) begin
                    b_addr[nbeats]  = bus.o_mem_addr;
                    b_mask[nbeats]  = bus.o_mem_bmask;
                    b_wdata[nbeats] = bus.o_mem_wdata;
                    b_we[nbeats]    = bus.o_mem_we;
                end
                nbeats++;
            end
            if (bus.o_rsp_valid) begin
                got_rsp = 1'b1;
                lat     = c;
                r_data  = bus.o_rsp_data;
                r_err   = bus.o_rsp_err;
            end
        end
        check_vec({tag, "/rsp_seen"}, got_rsp, 1);
    endtask

    task automatic expect_txn(input string tag, input int en,
                              input logic [31:0] a0, input logic [3:0] m0, input logic [31:0] w0,
                              input logic [31:0] a1, input logic [3:0] m1, input logic [31:0] w1,
                              input logic st, input logic [31:0] d, input logic e, input int el);
        check_vec({tag, "/beats"}, nbeats, en);
        check_vec({tag, "/latency"}, lat, el);
        check_vec({tag, "/data"}, r_data, d);
        check_vec({tag, "/err"}, r_err, e);
        if (en >= 1 && nbeats >= 1) begin
            check_vec({tag, "/addr0"}, b_addr[0], a0);
            check_vec({tag, "/mask0"}, b_mask[0], m0);
            check_vec({tag, "/we0"}, b_we[0], st);
            if (st) check_vec({tag, "/wdata0"}, b_wdata[0], w0);
        end
        if (en >= 2 && nbeats >= 2) begin
            check_vec({tag, "/addr1"}, b_addr[1], a1);
            check_vec({tag, "/mask1"}, b_mask[1], m1);
            check_vec({tag, "/we1"}, b_we[1], st);
            if (st) check_vec({tag, "/wdata1"}, b_wdata[1], w1);
        end
    endtask

    initial begin
        logic quiet;
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        mem[64]  = 32'h44332211;
        mem[65]  = 32'h88776655;
        mem[0]   = 32'h01020304;
        mem[127] = 32'hCAFEBABE;

        bus.i_req_valid    = 1'b0;
        bus.i_req_store    = 1'b0;
        bus.i_req_type     = 3'b000;
        bus.i_req_addr     = 32'd0;
        bus.i_req_wdata    = 32'd0;
        bus_nm.i_req_valid = 1'b0;
        bus_nm.i_req_store = 1'b0;
        bus_nm.i_req_type  = 3'b000;
        bus_nm.i_req_addr  = 32'd0;
        bus_nm.i_req_wdata = 32'd0;
        bus_nm.i_mem_rvalid = 1'b0;
        bus_nm.i_mem_rdata  = 32'd0;

        repeat (2) @(negedge clk);
        check_vec("reset/ready", bus.o_req_ready, 1);
        check_vec("reset/mem_req", bus.o_mem_req, 0);
        check_vec("reset/rsp_valid", bus.o_rsp_valid, 0);
        check_vec("reset/rsp_data", bus.o_rsp_data, 0);
        check_vec("reset/rsp_err", bus.o_rsp_err, 0);
        check_vec("reset/mem_addr", bus.o_mem_addr, 0);
        rst = 1'b0;

        access("LB103", 1'b0, 3'b000, 32'h103, 32'd0);
        expect_txn("LB103", 1, 32'h100, 4'b1000, 0, 0, 0, 0, 1'b0, 32'h00000044, 1'b0, 3);
        access("LB107", 1'b0, 3'b000, 32'h107, 32'd0);
        expect_txn("LB107", 1, 32'h104, 4'b1000, 0, 0, 0, 0, 1'b0, 32'hFFFFFF88, 1'b0, 3);
        access("LBU107", 1'b0, 3'b100, 32'h107, 32'd0);
        expect_txn("LBU107", 1, 32'h104, 4'b1000, 0, 0, 0, 0, 1'b0, 32'h00000088, 1'b0, 3);
        access("LH103", 1'b0, 3'b001, 32'h103, 32'd0);
        expect_txn("LH103", 2, 32'h100, 4'b1000, 0, 32'h104, 4'b0001, 0, 1'b0, 32'h00005544, 1'b0, 5);
        access("LW102", 1'b0, 3'b010, 32'h102, 32'd0);
        expect_txn("LW102", 2, 32'h100, 4'b1100, 0, 32'h104, 4'b0011, 0, 1'b0, 32'h66554433, 1'b0, 5);
        access("LH106", 1'b0, 3'b001, 32'h106, 32'd0);
        expect_txn("LH106", 1, 32'h104, 4'b1100, 0, 0, 0, 0, 1'b0, 32'hFFFF8877, 1'b0, 3);
        access("LHU105", 1'b0, 3'b101, 32'h105, 32'd0);
        expect_txn("LHU105", 1, 32'h104, 4'b0110, 0, 0, 0, 0, 1'b0, 32'h00007766, 1'b0, 3);

        access("SW101", 1'b1, 3'b010, 32'h101, 32'hAABBCCDD);
        expect_txn("SW101", 2, 32'h100, 4'b1110, 32'hBBCCDD00, 32'h104, 4'b0001, 32'h000000AA,
                   1'b1, 32'd0, 1'b0, 3);
        access("SB102", 1'b1, 3'b000, 32'h102, 32'h12345677);
        expect_txn("SB102", 1, 32'h100, 4'b0100, 32'h00770000, 0, 0, 0, 1'b1, 32'd0, 1'b0, 2);
        access("LW100", 1'b0, 3'b010, 32'h100, 32'd0);
        expect_txn("LW100", 1, 32'h100, 4'b1111, 0, 0, 0, 0, 1'b0, 32'hBB77DD11, 1'b0, 3);
        access("LW101", 1'b0, 3'b010, 32'h101, 32'd0);
        expect_txn("LW101", 2, 32'h100, 4'b1110, 0, 32'h104, 4'b0001, 0, 1'b0, 32'hAABB77DD, 1'b0, 5);

        access("LD011", 1'b0, 3'b011, 32'h100, 32'd0);
        expect_txn("LD011", 0, 0, 0, 0, 0, 0, 0, 1'b0, 32'd0, 1'b1, 1);
        access("ST011", 1'b1, 3'b011, 32'h100, 32'hFFFFFFFF);
        expect_txn("ST011", 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'd0, 1'b1, 1);

        access("LWwrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'd0);
        expect_txn("LWwrap", 2, 32'hFFFFFFFC, 4'b1100, 0, 32'h00000000, 4'b0011, 0,
                   1'b0, 32'h0304CAFE, 1'b0, 5);

        // misaligned word on the non-splitting instance
        @(negedge clk);
        bus_nm.i_req_valid = 1'b1;
        bus_nm.i_req_type  = 3'b010;
        bus_nm.i_req_addr  = 32'h102;
        check_vec("NM/ready", bus_nm.o_req_ready, 1);
        @(negedge clk);
        bus_nm.i_req_valid = 1'b0;
        check_vec("NM/mem_req", bus_nm.o_mem_req, 0);
        check_vec("NM/rsp_valid", bus_nm.o_rsp_valid, 1);
        check_vec("NM/rsp_err", bus_nm.o_rsp_err, 1);
        check_vec("NM/rsp_data", bus_nm.o_rsp_data, 0);
        @(negedge clk);
        check_vec("NM/pulse_end", bus_nm.o_rsp_valid, 0);
        check_vec("NM/ready_again", bus_nm.o_req_ready, 1);

        // reset in WAIT0 of a split load, stale rvalid afterwards
        resp_en = 1'b0;
        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_req_store = 1'b0;
        bus.i_req_type  = 3'b010;
        bus.i_req_addr  = 32'h102;
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        check_vec("ABORT/beat0", bus.o_mem_req, 1);
        @(negedge clk);
        check_vec("ABORT/wait0", bus.o_mem_req, 0);
        rst = 1'b1;
        #1;
        inj_valid = 1'b1;
        inj_data  = 32'h12345678;
        @(negedge clk);
        check_vec("ABORT/ready_in_reset", bus.o_req_ready, 1);
        rst = 1'b0;
        #1;
        inj_valid = 1'b0;
        @(negedge clk);
        check_vec("ABORT/ready_after", bus.o_req_ready, 1);
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bus.o_mem_req || bus.o_rsp_valid || !bus.o_req_ready) quiet = 1'b0;
            @(negedge clk);
        end
        check_vec("ABORT/quiet", quiet, 1);
        #1;
        resp_en = 1'b1;

        access("LB100", 1'b0, 3'b000, 32'h100, 32'd0);
        expect_txn("LB100", 1, 32'h100, 4'b0001, 0, 0, 0, 0, 1'b0, 32'h00000011, 1'b0, 3);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
